// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO, any DEPTH >= 2, standard or FWFT read.
// Ports: clk/rstn, winc/wdata, rinc/rdata, wfull/rempty, almost_*, count, overflow/underflow.
module sync_fifo_flex #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       winc,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rinc,
  output logic [WIDTH-1:0]           rdata,
  output logic                       wfull,
  output logic                       rempty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t LAST = ptr_t'(DEPTH - 1);
  localparam cnt_t FULL_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C = cnt_t'(AF_LEVEL);
  localparam cnt_t AE_C = cnt_t'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             full, empty, wen, ren;

  // Flags decode registered count only, never winc/rinc.
  assign full  = (count_q == FULL_C);
  assign empty = (count_q == '0);
  assign wen   = winc & ~full;
  assign ren   = rinc & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    ovf_d    = winc & full;
    unf_d    = rinc & empty;
    // Explicit wrap at DEPTH-1 so any depth works.
    if (wen) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (ren) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      if (FWFT == 0) begin
        rdata_d = mem_q[rd_ptr_q];
      end
    end
    unique case (1'b1)
      (wen & ~ren): count_d = count_q + 1'b1;
      (ren & ~wen): count_d = count_q - 1'b1;
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && wen) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      assign rdata = rdata_q;
    end
  endgenerate

  assign wfull        = full;
  assign rempty       = empty;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench: three FIFO configurations on shared stimulus,
// each checked against a queue model every cycle.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, winc, rinc;
  logic [7:0] wdata;

  logic [7:0] rd  [3];
  logic       wf  [3];
  logic       re  [3];
  logic       afl [3];
  logic       ael [3];
  logic [2:0] cnt [3];
  logic       ov  [3];
  logic       un  [3];

  int dep [3] = '{6, 6, 5};
  int fwt [3] = '{0, 1, 0};
  int afv [3] = '{4, 5, 3};
  int aev [3] = '{2, 1, 2};

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [7:0] mrd [3];
  logic       mov [3];
  logic       mun [3];

  sync_fifo_flex #(.WIDTH(8), .DEPTH(6), .FWFT(0)) d0 (
    .clk(clk), .rstn(rstn), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rd[0]), .wfull(wf[0]), .rempty(re[0]),
    .almost_full(afl[0]), .almost_empty(ael[0]), .count(cnt[0]),
    .overflow(ov[0]), .underflow(un[0]));

  sync_fifo_flex #(.WIDTH(8), .DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1),
                   .FWFT(1)) d1 (
    .clk(clk), .rstn(rstn), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rd[1]), .wfull(wf[1]), .rempty(re[1]),
    .almost_full(afl[1]), .almost_empty(ael[1]), .count(cnt[1]),
    .overflow(ov[1]), .underflow(un[1]));

  sync_fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(0)) d2 (
    .clk(clk), .rstn(rstn), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rd[2]), .wfull(wf[2]), .rempty(re[2]),
    .almost_full(afl[2]), .almost_empty(ael[2]), .count(cnt[2]),
    .overflow(ov[2]), .underflow(un[2]));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mstep(input int dp, input int fw, input bit rst,
                       input bit w, input bit r, input logic [7:0] d,
                       input logic [7:0] qi [$], output logic [7:0] qo [$],
                       input logic [7:0] rdi, output logic [7:0] rdo,
                       output logic ovo, output logic uno);
    bit full, empty;
    logic [7:0] h;
    qo  = qi;
    rdo = rdi;
    ovo = 1'b0;
    uno = 1'b0;
    if (rst) begin
      qo.delete();
      rdo = 8'h00;
    end else begin
      full  = (qi.size() == dp);
      empty = (qi.size() == 0);
      ovo   = w && full;
      uno   = r && empty;
      if (r && !empty) begin
        h = qo.pop_front();
        if (fw == 0) rdo = h;
      end
      if (w && !full) qo.push_back(d);
    end
  endtask

  task automatic checkall();
    int sz [3];
    logic [7:0] hd [3];
    logic [7:0] erd;
    string p;
    sz[0] = q0.size();
    sz[1] = q1.size();
    sz[2] = q2.size();
    hd[0] = (sz[0] > 0) ? q0[0] : 8'h00;
    hd[1] = (sz[1] > 0) ? q1[0] : 8'h00;
    hd[2] = (sz[2] > 0) ? q2[0] : 8'h00;
    for (int i = 0; i < 3; i++) begin
      p   = $sformatf("d%0d.", i);
      erd = (fwt[i] != 0) ? hd[i] : mrd[i];
      chk({p, "count"}, 32'(cnt[i]), 32'(sz[i]));
      chk({p, "wfull"}, 32'(wf[i]), 32'(sz[i] == dep[i]));
      chk({p, "rempty"}, 32'(re[i]), 32'(sz[i] == 0));
      chk({p, "almost_full"}, 32'(afl[i]), 32'(sz[i] >= afv[i]));
      chk({p, "almost_empty"}, 32'(ael[i]), 32'(sz[i] <= aev[i]));
      chk({p, "overflow"}, 32'(ov[i]), 32'(mov[i]));
      chk({p, "underflow"}, 32'(un[i]), 32'(mun[i]));
      chk({p, "rdata"}, 32'(rd[i]), 32'(erd));
    end
  endtask

  task automatic step(input bit rst, input bit w, input bit r,
                      input logic [7:0] d);
    rstn  = !rst;
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge clk);
    #1;
    mstep(6, 0, rst, w, r, d, q0, q0, mrd[0], mrd[0], mov[0], mun[0]);
    mstep(6, 1, rst, w, r, d, q1, q1, mrd[1], mrd[1], mov[1], mun[1]);
    mstep(5, 0, rst, w, r, d, q2, q2, mrd[2], mrd[2], mov[2], mun[2]);
    checkall();
  endtask

  initial begin
    int wn;
    int pre;
    bit w, r;
    rstn = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    for (int i = 0; i < 3; i++) begin
      mrd[i] = 8'h00; mov[i] = 1'b0; mun[i] = 1'b0;
    end
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);

    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'(8'h11 + i));
    step(0, 1, 0, 8'h77);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    step(0, 1, 0, 8'hA5);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);

    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'(8'h21 + i));
    step(0, 1, 1, 8'h99);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'h99);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    wn = 0;
    for (int k = 0; k < 400 && wn < 40; k++) begin
      w   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      pre = q2.size();
      step(0, w, r, 8'(wn));
      if (w && pre < 5) wn++;
    end
    chk("stream.words_written", 32'(wn), 32'd40);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h00);

    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'h41 + i));
    step(1, 1, 0, 8'h55);
    step(0, 1, 0, 8'h3C);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'(8'h61 + i));
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Single-clock, parametrised FIFO for same-domain buffering. It supports any depth, not only powers of two, and has two read modes: standard registered read and first-word-fall-through. It provides an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow pulses. It sits between producer and consumer logic in one clock domain, where the dual-clock FIFO is not needed.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, any integer)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard read, 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all logic on rising edge
rstn  input  1  synchronous active-low reset
winc  input  1  write request
wdata  input  WIDTH  write data
rinc  input  1  read request
rdata  output  WIDTH  read data
wfull  output  1  FIFO holds DEPTH entries
rempty  output  1  FIFO holds 0 entries
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: winc while wfull
underflow  output  1  one-cycle pulse: rinc while rempty

Behaviour:
- Reset: one clock, one reset. Reset is synchronous and active-low. It is sampled only on the rising edge of clk while rstn=0.
- Reset values: pointers=0, count=0, rempty=1, wfull=0, almost_empty=1, almost_full=0 (unless AF_LEVEL=0, which is illegal), overflow=0, underflow=0, rdata=0.
- Storage array is not reset.
- Reset mid-operation discards all contents. It has no effect on the first post-reset cycle beyond the reset values above.
- Accepted write: wen = winc & !wfull. It stores wdata at wr_ptr.
- Accepted read: ren = rinc & !rempty. It consumes the entry at rd_ptr.
- Flags use registered state only. Combinational paths from winc/rinc to wfull/rempty are not allowed.
- Pointer wrap: pointers run 0..DEPTH-1 and wrap to 0 after DEPTH-1. Binary rollover is not used, so non-power-of-two DEPTH must work.
- count update:
  - +1 on wen only
  - -1 on ren only
  - unchanged on both or neither
  - never exceeds DEPTH, never below 0
- All flags and count are registered. They reflect accepted operations one cycle after the accepting edge.
- Simultaneous winc and rinc:
  - Full: the read is accepted and the write is rejected (wfull sampled before the edge). The result is count = DEPTH-1 and overflow = 1.
  - Empty: the write is accepted and the read is rejected. The result is count = 1 and underflow = 1.
  - Otherwise: both are accepted and count is unchanged.
- overflow/underflow: registered one-cycle pulses in the cycle after the offending request. Rejected operations do not alter pointers, storage or rdata.
- FWFT=0 read path:
  - rdata is registered and loads mem[rd_ptr] on an accepted read. Latency is 1 cycle from the rinc edge.
  - rdata holds its value when no read is accepted.
- FWFT=1 read path:
  - rdata = mem[rd_ptr] whenever rempty=0; rdata = 0 when rempty=1.
  - The head word is visible in the cycle after the write that made the FIFO non-empty.
  - An accepted rinc pops the head; the next word appears in the following cycle.
- Data ordering is strict FIFO. There is no loss and no duplication across any number of wraps.

Test Plan:
1. DEPTH=6, WIDTH=8, FWFT=0. Reset, write 0x11..0x16 on 6 consecutive cycles -> wfull=1, count=6, almost_full=1 at AF_LEVEL=4 from count 4. A 7th write of 0x77 -> overflow pulse, count stays 6. Then read 6 times -> rdata 0x11..0x16, each 1 cycle after its rinc; rempty=1.
2. DEPTH=6, FWFT=1. Write 0xA5 -> the next cycle shows rempty=0 and rdata=0xA5 without rinc. Then rinc -> rempty=1, rdata=0.
3. DEPTH=6, full. Assert winc=1 and rinc=1 with wdata=0x99 for 1 cycle -> count=5, overflow=1, 0x99 never read out. Repeat when empty -> count=1, underflow=1, a later read returns 0x99.
4. DEPTH=5 (non-power-of-two). Stream 40 words 0x00..0x27 with random winc/rinc at about 50% each -> output sequence equals input, count always 0..5, flags consistent with count every cycle.
5. Fill to count=4, assert rstn=0 for 1 cycle mid-stream -> next cycle count=0, rempty=1, wfull=0, rdata=0. Then write 0x3C and read -> 0x3C.
6. AE_LEVEL=1, AF_LEVEL=5, DEPTH=6. Step count 0→6→0 -> almost_empty=1 only at counts 0–1, almost_full=1 only at counts 5–6.
